bwt_mem_req_arbiter: RTL

- Shares the single BWT occurrence-table memory read port between the forward and backward data paths.
- Each path issues one request per cycle: request_valid plus addr_k and addr_l (42-bit cacheline addresses) and a read number.
- The block buffers requests per source and arbitrates round-robin between the two sources.
- Each request is serialised into one or two memory reads. The memory interface uses a valid/ready handshake. A tag on each read lets responses be routed back to the right path.

---
 rtl/bwt_mem_req_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/bwt_mem_req_arbiter.sv
// rtl/bwt_mem_req_arbiter.sv - forward/backward BWT occurrence-table read arbiter
//
// Purpose: buffers forward and backward lookup requests in per-source FIFOs,
// picks between the two sources round-robin, and turns each request into one
// read (k and l share a cacheline) or two reads (k, then l) on a valid/ready
// memory port. Each read is tagged so the response can be routed back.
//
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   fwd_req_valid/addr_k/addr_l/read_num, fwd_stall    forward request side
//   bck_req_valid/addr_k/addr_l/read_num, bck_stall    backward request side
//   mem_req_valid/ready/addr/tag                        memory read port
//                              tag = {src, kind[1:0], read_num}
//   overflow_err               sticky: push into a full FIFO was dropped
//   busy                       work pending in a FIFO or the hold register

module bwt_mem_req_arbiter #(
    parameter int unsigned ADDR_W = 42,
    parameter int unsigned RN_W   = 9,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fwd_req_valid,
    input  logic [ADDR_W-1:0] fwd_addr_k,
    input  logic [ADDR_W-1:0] fwd_addr_l,
    input  logic [RN_W-1:0]   fwd_read_num,
    output logic              fwd_stall,
    input  logic              bck_req_valid,
    input  logic [ADDR_W-1:0] bck_addr_k,
    input  logic [ADDR_W-1:0] bck_addr_l,
    input  logic [RN_W-1:0]   bck_read_num,
    output logic              bck_stall,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [RN_W+2:0]   mem_req_tag,
    output logic              overflow_err,
    output logic              busy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned EW    = 2 * ADDR_W + RN_W;

    localparam logic [1:0] KIND_K      = 2'b00;
    localparam logic [1:0] KIND_L      = 2'b01;
    localparam logic [1:0] KIND_SHARED = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE_K = 2'd1,
        ISSUE_L = 2'd2
    } state_t;

    // Index 0 = forward, 1 = backward throughout.
    logic [EW-1:0]    fifo_q   [2][DEPTH];
    logic [PTR_W-1:0] wr_ptr_q [2];
    logic [PTR_W-1:0] rd_ptr_q [2];
    logic [CNT_W-1:0] cnt_q    [2];
    logic [CNT_W-1:0] cnt_d    [2];
    logic [EW-1:0]    push_data[2];
    logic [1:0]       push, pop, accept, full, nonempty;
    logic [1:0]       stall_q, overflow_q;

    state_t            state_q;
    logic              req_valid_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [RN_W+2:0]   req_tag_q;
    logic [ADDR_W-1:0] hold_l_q;
    logic              pref_bck_q;

    logic              release_req, can_grant, do_grant, grant_bck;
    logic [EW-1:0]     grant_entry;
    logic [ADDR_W-1:0] load_k, load_l;
    logic [RN_W-1:0]   load_rn;
    logic [RN_W+2:0]   load_tag;

    always_comb begin
        push         = {bck_req_valid, fwd_req_valid};
        push_data[0] = {fwd_addr_k, fwd_addr_l, fwd_read_num};
        push_data[1] = {bck_addr_k, bck_addr_l, bck_read_num};
        for (int s = 0; s < 2; s++) begin
            full[s]     = (cnt_q[s] == CNT_W'(DEPTH));
            nonempty[s] = (cnt_q[s] != '0);
        end
    end

    // The hold register frees up either from IDLE or on the handshake of the
    // request's last read; in both cases the next entry is popped this cycle.
    always_comb begin
        release_req = req_valid_q && mem_req_ready &&
                      ((state_q == ISSUE_L) ||
                       ((state_q == ISSUE_K) && (req_tag_q[RN_W+1:RN_W] == KIND_SHARED)));
        can_grant   = (state_q == IDLE) || release_req;
        do_grant    = can_grant && (|nonempty);
        grant_bck   = (&nonempty) ? pref_bck_q : nonempty[1];
        pop[0]      = do_grant && !grant_bck;
        pop[1]      = do_grant && grant_bck;
        grant_entry = grant_bck ? fifo_q[1][rd_ptr_q[1]] : fifo_q[0][rd_ptr_q[0]];
        {load_k, load_l, load_rn} = grant_entry;
        load_tag    = {grant_bck, (load_k == load_l) ? KIND_SHARED : KIND_K, load_rn};
    end

    // A pop in the same cycle frees a slot, so a push into a full FIFO that is
    // also being popped is accepted.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            accept[s] = push[s] && (!full[s] || pop[s]);
            cnt_d[s]  = cnt_q[s] + CNT_W'(accept[s]) - CNT_W'(pop[s]);
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (accept[s]) begin
                fifo_q[s][wr_ptr_q[s]] <= push_data[s];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < 2; s++) begin
                wr_ptr_q[s] <= '0;
                rd_ptr_q[s] <= '0;
                cnt_q[s]    <= '0;
            end
            stall_q    <= '0;
            overflow_q <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (accept[s]) begin
                    wr_ptr_q[s] <= wr_ptr_q[s] + PTR_W'(1);
                end
                if (pop[s]) begin
                    rd_ptr_q[s] <= rd_ptr_q[s] + PTR_W'(1);
                end
                cnt_q[s] <= cnt_d[s];
                // One slot of slack covers the source's one-cycle reaction.
                stall_q[s] <= (cnt_d[s] >= CNT_W'(DEPTH - 1));
                if (push[s] && !accept[s]) begin
                    overflow_q[s] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_tag_q   <= '0;
            hold_l_q    <= '0;
            pref_bck_q  <= 1'b0;
        end else if (do_grant) begin
            state_q     <= ISSUE_K;
            req_valid_q <= 1'b1;
            req_addr_q  <= load_k;
            req_tag_q   <= load_tag;
            hold_l_q    <= load_l;
            pref_bck_q  <= !grant_bck;
        end else begin
            case (state_q)
                ISSUE_K: begin
                    if (mem_req_ready) begin
                        if (req_tag_q[RN_W+1:RN_W] == KIND_SHARED) begin
                            state_q     <= IDLE;
                            req_valid_q <= 1'b0;
                        end else begin
                            state_q                   <= ISSUE_L;
                            req_addr_q                <= hold_l_q;
                            req_tag_q[RN_W+1:RN_W]    <= KIND_L;
                        end
                    end
                end
                ISSUE_L: begin
                    if (mem_req_ready) begin
                        state_q     <= IDLE;
                        req_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign fwd_stall     = stall_q[0];
    assign bck_stall     = stall_q[1];
    assign overflow_err  = |overflow_q;
    assign mem_req_valid = req_valid_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_tag   = req_tag_q;
    assign busy          = (|nonempty) || (state_q != IDLE);

endmodule
